// File: rtl/trap_ctrl.sv
// Trap sequencer between the MEM stage and csr: arbitrates exceptions against the
// external interrupt, feeds csr for one commit cycle, then flushes and redirects.
module trap_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter bit IRQ_LEVEL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        int_req_i,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_addr_i,
   input  logic        ecall_i,
   input  logic        illegal_i,
   input  logic        mret_i,
   input  logic        stall_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mie_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   output logic [31:0] excepttype_o,
   output logic        int_o,
   output logic [31:0] current_inst_addr_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        stallreq_o
);
   // state      | meaning
   // S_IDLE     | watching MEM stage for a trap or a deliverable interrupt
   // S_TAKE     | one cycle presenting code/addr to csr, which commits at its end
   // S_REDIRECT | flush + redirect PC, held while the pipeline is stalled
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_TAKE     = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0] C_ILL   = 4'hA;
   localparam logic [3:0] C_ECALL = 4'h8;
   localparam logic [3:0] C_MRET  = 4'hE;
   localparam logic [3:0] C_IRQ   = 4'h1;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_irq_prev;
   logic                   r_pend;
   logic [3:0]             r_code;
   logic [3:0]             w_code;
   logic [31:0]            r_addr;
   logic                   w_irq_s;
   logic                   w_pend;
   logic                   w_int_en;
   logic                   w_detect;
   logic                   w_unused;

   assign w_irq_s  = r_sync[SYNC_STAGES-1];
   assign w_pend   = IRQ_LEVEL ? w_irq_s : r_pend;
   assign w_int_en = mstatus_i[3] & mie_i[11];
   assign w_unused = ^{mstatus_i[31:4], mstatus_i[2:0], mie_i[31:12], mie_i[10:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync     <= '0;
         r_irq_prev <= 1'b0;
         r_pend     <= 1'b0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], int_req_i};
         r_irq_prev <= w_irq_s;
         // a fresh edge outranks the clear from an interrupt being taken
         if (w_irq_s && !r_irq_prev)
            r_pend <= 1'b1;
         else if (r_state == S_TAKE && r_code == C_IRQ)
            r_pend <= 1'b0;
      end
   end

   // rst gates detect so every output is 0 while reset is held
   always_comb begin
      w_code   = C_IRQ;
      w_detect = 1'b0;
      if (rst && r_state == S_IDLE && inst_valid_i && !stall_i) begin
         if (illegal_i) begin
            w_code   = C_ILL;
            w_detect = 1'b1;
         end else if (ecall_i) begin
            w_code   = C_ECALL;
            w_detect = 1'b1;
         end else if (mret_i) begin
            w_code   = C_MRET;
            w_detect = 1'b1;
         end else if (w_pend && w_int_en) begin
            w_code   = C_IRQ;
            w_detect = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_code  <= 4'h0;
         r_addr  <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_detect) begin
            r_code <= w_code;
            r_addr <= inst_addr_i;
         end
      end
   end

   always_comb begin
      w_state_nxt         = r_state;
      excepttype_o        = 32'h0;
      int_o               = 1'b0;
      current_inst_addr_o = 32'h0;
      flush_o             = 1'b0;
      new_pc_o            = 32'h0;
      stallreq_o          = w_detect;
      case (r_state)
         S_IDLE: begin
            if (w_detect)
               w_state_nxt = S_TAKE;
         end
         S_TAKE: begin
            excepttype_o        = {28'h0, r_code};
            int_o               = (r_code == C_IRQ);
            current_inst_addr_o = r_addr;
            stallreq_o          = 1'b1;
            w_state_nxt         = S_REDIRECT;
         end
         S_REDIRECT: begin
            flush_o    = 1'b1;
            new_pc_o   = (r_code == C_MRET) ? mepc_i : mtvec_i;
            stallreq_o = 1'b1;
            if (!stall_i)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer that sits directly upstream of the csr block.
- Collects synchronous exception flags from the MEM stage and the external interrupt line, arbitrates between them, and drives excepttype/int/current_inst_addr into csr.
- One cycle after csr commits its trap state, issues a pipeline flush and a redirect PC: mtvec for a trap, mepc for mret.
- Asserts a stall request while the sequence is in flight.

Parameters:
SYNC_STAGES, 2, depth of the int_req_i synchroniser; legal 2..3.
IRQ_LEVEL, 1, 1 = level-sensitive interrupt; 0 = rising-edge latched, cleared when taken.

Ports:
clk  in  1  system clock; everything on posedge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
int_req_i  in  1  external interrupt, asynchronous to clk.
inst_valid_i  in  1  MEM stage holds a valid retiring instruction.
inst_addr_i  in  32  PC of the MEM-stage instruction.
ecall_i  in  1  MEM instruction is ecall.
illegal_i  in  1  MEM instruction is invalid.
mret_i  in  1  MEM instruction is mret.
stall_i  in  1  pipeline frozen by bus/other stall.
mstatus_i  in  32  csr mstatus_o (bit 3 = MIE).
mie_i  in  32  csr mie_o (bit 11 = MEIE).
mtvec_i  in  32  csr mtvec_o.
mepc_i  in  32  csr mepc_o.
excepttype_o  out  32  to csr excepttype_i.
int_o  out  1  to csr int_i.
current_inst_addr_o  out  32  to csr current_inst_addr_i.
flush_o  out  1  flush all pipeline stages.
new_pc_o  out  32  redirect target, valid while flush_o=1.
stallreq_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset: state IDLE; sync flops, pending, latched code and latched addr all 0; every output 0.
- Reset is asynchronous. Asserting it mid-sequence aborts to IDLE at once, with no flush.

Interrupt path:
- irq_s is the last stage of a SYNC_STAGES-flop chain on int_req_i.
- IRQ_LEVEL=1: pending = irq_s.
- IRQ_LEVEL=0: pending sets on a 0->1 edge of irq_s. It clears on the TAKE cycle of an interrupt. If a set and a clear coincide, the set wins.
- int_en = mstatus_i[3] & mie_i[11].

Trap detect (IDLE only, combinational):
- Qualifier: inst_valid_i & !stall_i.
- Priority, highest first:
  - illegal_i -> code 0x0000000A
  - ecall_i -> code 0x00000008
  - mret_i -> code 0x0000000E
  - pending & int_en -> code 0x00000001
- A synchronous exception always beats an interrupt on the same cycle. The interrupt stays pending.
- Bubbles (inst_valid_i=0) never trap; a pending interrupt waits for the next valid instruction.

FSM:
- IDLE: on detect, latch code and inst_addr_i, then go to TAKE.
- TAKE: exactly 1 cycle, stall_i ignored.
  - excepttype_o = latched code.
  - current_inst_addr_o = latched addr.
  - int_o = 1 only if code = 0x1.
  - csr commits at the end of this cycle.
  - Next state: REDIRECT.
- REDIRECT:
  - excepttype_o = 0, int_o = 0.
  - flush_o = 1.
  - new_pc_o = mepc_i if code = 0xE, else mtvec_i. Both are read from csr after its update.
  - Stays while stall_i=1, holding flush_o and new_pc_o. Goes to IDLE on the first cycle with stall_i=0.

Outputs:
- stallreq_o = (state != IDLE) | detect. It is combinational in the detect cycle so the trapping instruction cannot advance.
- In IDLE, excepttype_o, int_o, current_inst_addr_o, flush_o and new_pc_o are all 0.

Other boundary rules:
- An interrupt arriving during TAKE or REDIRECT is retained (edge mode) or re-sampled (level mode). csr has cleared MIE by then, so the interrupt is not taken until mret restores MIE.
- A new detect is never evaluated outside IDLE, so back-to-back traps are separated by at least one IDLE cycle.

Test Plan:
- Ecall: ecall_i=1, inst_valid_i=1, inst_addr_i=0x100, mtvec ends at 0x40 -> stallreq_o=1 at once. Next cycle excepttype_o=0x8, current_inst_addr_o=0x100, int_o=0. Then flush_o=1 with new_pc_o=0x40 for 1 cycle.
- Illegal and ecall together: both high -> excepttype_o=0xA. Only one trap sequence runs.
- Interrupt, edge mode (IRQ_LEVEL=0): mstatus=0x8, mie=0x800, 1-cycle int_req_i pulse -> after SYNC_STAGES+1 cycles and a valid instruction, excepttype_o=0x1 with int_o=1, then new_pc_o=mtvec_i. A second pulse while MIE=0 stays pending and is taken after mret.
- Interrupt masked and bubbles: mie_i=0, or inst_valid_i=0 -> no TAKE, stallreq_o stays 0.
- mret with stall: mret_i with mepc_i=0x204 -> excepttype_o=0xE, then new_pc_o=0x204. Holding stall_i=1 for 3 cycles in REDIRECT keeps flush_o=1 for 3 cycles plus 1.
- Reset mid-sequence: rst=0 during REDIRECT -> flush_o, stallreq_o and excepttype_o go to 0 immediately without a clock edge; state returns to IDLE.
